// File: rtl/jtframe_68kdma_arb_pkg.sv
// Shared types and helpers for the 68000 DMA bus-master arbiter.
package jtframe_68kdma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  // Width of a device index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_68kdma_prio.sv
// Combinational priority picker: lowest set request index, or with
// round-robin the first set index at or after i_ptr with wrap-around.
module jtframe_68kdma_prio
  import jtframe_68kdma_arb_pkg::*;
#(
  parameter int BW = 2,
  parameter int PW = idx_width(BW)
) (
  input  logic [BW-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_rr,
  output logic          o_valid,
  output logic [PW-1:0] o_win
);

  // Scan BW candidates starting at the pointer; the wrap is explicit
  // because BW need not be a power of two.
  always_comb begin
    int unsigned w_start;
    int unsigned w_idx;
    o_valid = 1'b0;
    o_win   = '0;
    w_start = i_rr ? 32'(i_ptr) : 32'd0;
    for (int unsigned k = 0; k < BW; k++) begin
      w_idx = w_start + k;
      if (w_idx >= BW) w_idx = w_idx - BW;
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_win   = PW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/jtframe_68kdma_arb.sv
// 68000 bus-master arbiter: requests the CPU bus on behalf of BW DMA
// devices, grants one device per tenure and optionally limits tenure length.
module jtframe_68kdma_arb
  import jtframe_68kdma_arb_pkg::*;
#(
  parameter int BW      = 2,
  parameter int RR      = 0,
  parameter int MAXHOLD = 0,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic          cpu_BRn,
  output logic          cpu_BGACKn,
  input  logic          cpu_BGn,
  input  logic          cpu_ASn,
  input  logic          cpu_DTACKn,
  input  logic [BW-1:0] dev_br,
  output logic [BW-1:0] dev_bg,
  output logic          hold_to
);

  localparam int PW = idx_width(BW);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);

  arb_state_t    r_state, w_state_nxt;
  logic [PW-1:0] r_sel, w_sel_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_brn, w_brn_nxt;
  logic          r_bgackn, w_bgackn_nxt;
  logic [BW-1:0] r_bg, w_bg_nxt;
  logic          r_hto, w_hto_nxt;

  logic          w_valid;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_inc;
  logic          w_timeout;
  logic          w_grant_ok;

  jtframe_68kdma_prio #(
    .BW (BW),
    .PW (PW)
  ) u_prio (
    .i_req   (dev_br),
    .i_ptr   (r_ptr),
    .i_rr    (RR != 0),
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  assign w_ptr_inc  = (32'(r_sel) + 32'd1 >= 32'(BW)) ? '0 : r_sel + PW'(1);
  assign w_timeout  = (MAXHOLD != 0) && (r_cnt == HOLD_LAST);
  assign w_grant_ok = !cpu_BGn && cpu_ASn && cpu_DTACKn;

  // Next-state and registered-output decisions for each arbitration phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_brn_nxt    = r_brn;
    w_bgackn_nxt = r_bgackn;
    w_bg_nxt     = r_bg;
    w_hto_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_sel_nxt   = w_win;
          w_brn_nxt   = 1'b0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!dev_br[r_sel]) begin
          w_brn_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_grant_ok) begin
          w_bgackn_nxt = 1'b0;
          w_brn_nxt    = 1'b1;
          w_bg_nxt     = BW'(1) << r_sel;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_OWN;
        end
      end
      ST_OWN: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!dev_br[r_sel] || w_timeout) begin
          w_bg_nxt     = '0;
          w_bgackn_nxt = 1'b1;
          // Request still high here means the release came from the hold
          // limit alone; a simultaneous drop counts as a normal end.
          w_hto_nxt    = dev_br[r_sel];
          w_state_nxt  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (RR != 0) w_ptr_nxt = w_ptr_inc;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers, advancing only on clock-enable ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_brn    <= 1'b1;
      r_bgackn <= 1'b1;
      r_bg     <= '0;
      r_hto    <= 1'b0;
    end else if (cen) begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_brn    <= w_brn_nxt;
      r_bgackn <= w_bgackn_nxt;
      r_bg     <= w_bg_nxt;
      r_hto    <= w_hto_nxt;
    end
  end

  assign cpu_BRn    = r_brn;
  assign cpu_BGACKn = r_bgackn;
  assign dev_bg     = r_bg;
  assign hold_to    = r_hto;

endmodule
